inst_fetch_ctrl: RTL and testbench

- Fetch-stage controller between the datapath PC (pcF) and the instruction-side SRAM-like bus (I-cache/AXI bridge).
- Issues one fetch per PC and returns the instruction as instrF.
- Generates stallreq_from_if, is_clear, i_data_ok and IF_pc for the hazard unit and datapath.
- Tracks at most one outstanding request, and discards a response that belongs to a flushed (exception/ERET) fetch.

---
 rtl/inst_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_ctrl
//  Purpose  : Fetch-stage controller between the datapath PC and the
//             instruction-side SRAM-like bus. Issues one fetch per PC,
//             returns the instruction, and drives the hazard-unit handshake
//             (stallreq_from_if / is_clear / i_data_ok). Holds at most one
//             outstanding request and discards responses of flushed fetches.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] BAD_INST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pcF,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic [INST_W-1:0] instrF,
   output logic [31:0]       IF_pc,
   output logic              stallreq_from_if,
   output logic              is_clear,
   output logic              i_data_ok,
   output logic              inst_req,
   output logic              inst_wr,
   output logic [1:0]        inst_size,
   output logic [31:0]       inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [INST_W-1:0] inst_rdata
);

   localparam logic [1:0] c_sizeWord = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_DONE = 3'd3,
      S_DROP = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_stateNext;
   logic [INST_W-1:0]   r_instr;
   logic [31:0]         r_ifPc;
   logic [31:0]         r_reqPc;
   logic                r_dataOk;

   logic                w_misaligned;
   logic                w_capture;     // valid bus data lands in instrF
   logic                w_loadBad;     // misaligned PC: publish BAD_INST
   logic                w_accept;      // request accepted, remember its PC

   assign w_misaligned = (pcF[1:0] != 2'b00);

   // State register and the instruction / PC holding registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_instr  <= '0;
         r_ifPc   <= '0;
         r_reqPc  <= '0;
         r_dataOk <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_dataOk <= w_capture;
         if (w_accept) begin
            r_reqPc <= pcF;
         end
         if (w_capture) begin
            r_instr <= inst_rdata;
            r_ifPc  <= r_reqPc;
         end else if (w_loadBad) begin
            r_instr <= BAD_INST;
            r_ifPc  <= pcF;
         end
      end
   end

   // Next-state decode and per-state bus / hazard outputs
   always_comb begin
      w_stateNext      = r_state;
      w_capture        = 1'b0;
      w_loadBad        = 1'b0;
      w_accept         = 1'b0;
      inst_req         = 1'b0;
      stallreq_from_if = 1'b1;
      is_clear         = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_stateNext = S_REQ;
         end
         S_REQ: begin
            if (w_misaligned) begin
               // Never put a misaligned address on the bus; the exception
               // is reported elsewhere, decode simply receives BAD_INST.
               w_loadBad   = 1'b1;
               w_stateNext = S_DONE;
            end else begin
               inst_req = 1'b1;
               if (flush_i) begin
                  // An accepted request under flush still owes a response
                  // that must be swallowed before the redirect fetch.
                  w_stateNext = inst_addr_ok ? S_DROP : S_REQ;
               end else if (inst_addr_ok) begin
                  w_accept    = 1'b1;
                  w_stateNext = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (flush_i) begin
               w_stateNext = inst_data_ok ? S_REQ : S_DROP;
            end else if (inst_data_ok) begin
               w_capture   = 1'b1;
               w_stateNext = S_DONE;
            end
         end
         S_DROP: begin
            is_clear = 1'b1;
            if (inst_data_ok) begin
               w_stateNext = S_REQ;
            end
         end
         S_DONE: begin
            stallreq_from_if = 1'b0;
            if (!stall_i || flush_i) begin
               w_stateNext = S_REQ;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // Address is only meaningful while a request is driven; keep it quiet
   // otherwise so the bus sees zero in every non-request cycle.
   assign inst_addr = inst_req ? {pcF[31:2], 2'b00} : 32'h0;
   assign inst_wr   = 1'b0;
   assign inst_size = c_sizeWord;
   assign instrF    = r_instr;
   assign IF_pc     = r_ifPc;
   assign i_data_ok = r_dataOk;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_ctrl
//  Purpose  : Directed cycle-by-cycle vector bench for inst_fetch_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] pcF;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] instrF;
   logic [31:0] IF_pc;
   logic        stallreq_from_if;
   logic        is_clear;
   logic        i_data_ok;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   int nVec;
   int nBad;

   inst_fetch_ctrl #(.INST_W(32), .BAD_INST(32'h00000000)) dut (
      .clk              (clk),
      .rst              (rst),
      .pcF              (pcF),
      .stall_i          (stall_i),
      .flush_i          (flush_i),
      .instrF           (instrF),
      .IF_pc            (IF_pc),
      .stallreq_from_if (stallreq_from_if),
      .is_clear         (is_clear),
      .i_data_ok        (i_data_ok),
      .inst_req         (inst_req),
      .inst_wr          (inst_wr),
      .inst_size        (inst_size),
      .inst_addr        (inst_addr),
      .inst_addr_ok     (inst_addr_ok),
      .inst_data_ok     (inst_data_ok),
      .inst_rdata       (inst_rdata)
   );

   // Free-running clock, posedge at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        stall;
      logic        flush;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic [31:0] eInstr;
      logic [31:0] ePc;
      logic        eStallreq;
      logic        eClear;
      logic        eDok;
      logic        eReq;
      logic [31:0] eAddr;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [31:0] pc, input logic st,
                               input logic fl, input logic aok, input logic dok,
                               input logic [31:0] rd, input logic [31:0] eI,
                               input logic [31:0] eP, input logic eS, input logic eC,
                               input logic eD, input logic eR, input logic [31:0] eA);
      vec_t v;
      v = '{r, pc, st, fl, aok, dok, rd, eI, eP, eS, eC, eD, eR, eA};
      vecs.push_back(v);
   endfunction

   // Outputs are compared 1 time unit after inputs settle, mid-cycle.
   task automatic check(input string name, input logic [31:0] eI, input logic [31:0] eP,
                        input logic eS, input logic eC, input logic eD,
                        input logic eR, input logic [31:0] eA);
      nVec++;
      if (instrF !== eI || IF_pc !== eP || stallreq_from_if !== eS || is_clear !== eC ||
          i_data_ok !== eD || inst_req !== eR || inst_addr !== eA ||
          inst_wr !== 1'b0 || inst_size !== 2'b10) begin
         nBad++;
         $display("FAIL %s: got instrF=%h IF_pc=%h stallreq=%b clear=%b dok=%b req=%b addr=%h wr=%b size=%b; want instrF=%h IF_pc=%h stallreq=%b clear=%b dok=%b req=%b addr=%h wr=0 size=10",
                  name, instrF, IF_pc, stallreq_from_if, is_clear, i_data_ok, inst_req,
                  inst_addr, inst_wr, inst_size, eI, eP, eS, eC, eD, eR, eA);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] pc, input logic st,
                        input logic fl, input logic aok, input logic dok,
                        input logic [31:0] rd);
      @(negedge clk);
      rst          = r;
      pcF          = pc;
      stall_i      = st;
      flush_i      = fl;
      inst_addr_ok = aok;
      inst_data_ok = dok;
      inst_rdata   = rd;
      #1;
   endtask

   localparam logic [31:0] A  = 32'hbfc00000;
   localparam logic [31:0] A2 = 32'hbfc00002;
   localparam logic [31:0] A4 = 32'hbfc00004;
   localparam logic [31:0] A8 = 32'hbfc00008;
   localparam logic [31:0] V  = 32'hbfc00380;

   initial begin
      nVec = 0;
      nBad = 0;
      rst = 1'b1; pcF = A; stall_i = 1'b0; flush_i = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
      repeat (2) @(posedge clk);

      //  rst pc  st fl aok dok rdata          instrF        IF_pc sr cl dk rq addr
      add(1, A,  0, 0, 0, 0, 32'h0,         32'h0,        32'h0, 1, 0, 0, 0, 32'h0);
      add(0, A,  0, 0, 0, 0, 32'h0,         32'h0,        32'h0, 1, 0, 0, 0, 32'h0);
      // basic zero-wait fetch
      add(0, A,  0, 0, 1, 0, 32'h0,         32'h0,        32'h0, 1, 0, 0, 1, A);
      add(0, A,  0, 0, 0, 1, 32'h3c080001,  32'h0,        32'h0, 1, 0, 0, 0, 32'h0);
      add(0, A,  0, 0, 0, 0, 32'h0,         32'h3c080001, A,     0, 0, 1, 0, 32'h0);
      // 3-cycle data latency
      add(0, A4, 0, 0, 1, 0, 32'h0,         32'h3c080001, A,     1, 0, 0, 1, A4);
      add(0, A4, 0, 0, 0, 0, 32'h0,         32'h3c080001, A,     1, 0, 0, 0, 32'h0);
      add(0, A4, 0, 0, 0, 0, 32'h0,         32'h3c080001, A,     1, 0, 0, 0, 32'h0);
      add(0, A4, 0, 0, 0, 1, 32'h24090002,  32'h3c080001, A,     1, 0, 0, 0, 32'h0);
      // stall held 5 cycles in DONE, then released
      add(0, A4, 1, 0, 0, 0, 32'h0,         32'h24090002, A4,    0, 0, 1, 0, 32'h0);
      for (int i = 0; i < 4; i++)
         add(0, A4, 1, 0, 0, 0, 32'h0,      32'h24090002, A4,    0, 0, 0, 0, 32'h0);
      add(0, A4, 0, 0, 0, 0, 32'h0,         32'h24090002, A4,    0, 0, 0, 0, 32'h0);
      add(0, A8, 0, 0, 0, 0, 32'h0,         32'h24090002, A4,    1, 0, 0, 1, A8);
      add(0, A8, 0, 0, 1, 0, 32'h0,         32'h24090002, A4,    1, 0, 0, 1, A8);
      // flush in WAIT, stale data two cycles later
      add(0, A8, 0, 1, 0, 0, 32'h0,         32'h24090002, A4,    1, 0, 0, 0, 32'h0);
      add(0, V,  0, 0, 0, 0, 32'h0,         32'h24090002, A4,    1, 1, 0, 0, 32'h0);
      add(0, V,  0, 0, 0, 1, 32'hdeadbeef,  32'h24090002, A4,    1, 1, 0, 0, 32'h0);
      add(0, V,  0, 0, 1, 0, 32'h0,         32'h24090002, A4,    1, 0, 0, 1, V);
      add(0, V,  0, 0, 0, 1, 32'h8c020010,  32'h24090002, A4,    1, 0, 0, 0, 32'h0);
      add(0, V,  0, 0, 0, 0, 32'h0,         32'h8c020010, V,     0, 0, 1, 0, 32'h0);
      // misaligned PC: no bus request, BAD_INST published
      add(0, A2, 0, 0, 0, 0, 32'h0,         32'h8c020010, V,     1, 0, 0, 0, 32'h0);
      add(0, A2, 0, 0, 0, 0, 32'h0,         32'h0,        A2,    0, 0, 0, 0, 32'h0);
      // flush in REQ with accept -> DROP
      add(0, A4, 0, 1, 1, 0, 32'h0,         32'h0,        A2,    1, 0, 0, 1, A4);
      add(0, V,  0, 0, 0, 0, 32'h0,         32'h0,        A2,    1, 1, 0, 0, 32'h0);
      add(0, V,  0, 0, 0, 1, 32'h11111111,  32'h0,        A2,    1, 1, 0, 0, 32'h0);
      // flush in REQ without accept -> re-issue
      add(0, V,  0, 1, 0, 0, 32'h0,         32'h0,        A2,    1, 0, 0, 1, V);
      add(0, V,  0, 0, 1, 0, 32'h0,         32'h0,        A2,    1, 0, 0, 1, V);
      // flush and data together in WAIT -> discard, back to REQ
      add(0, V,  0, 1, 0, 1, 32'h22222222,  32'h0,        A2,    1, 0, 0, 0, 32'h0);
      add(0, V,  0, 0, 1, 0, 32'h0,         32'h0,        A2,    1, 0, 0, 1, V);
      add(0, V,  0, 0, 0, 1, 32'h33333333,  32'h0,        A2,    1, 0, 0, 0, 32'h0);
      // flush overrides stall in DONE
      add(0, V,  1, 1, 0, 0, 32'h0,         32'h33333333, V,     0, 0, 1, 0, 32'h0);
      // spurious data_ok in REQ is ignored
      add(0, V,  0, 0, 0, 1, 32'h44444444,  32'h33333333, V,     1, 0, 0, 1, V);
      add(0, V,  0, 0, 1, 0, 32'h0,         32'h33333333, V,     1, 0, 0, 1, V);
      add(0, V,  0, 0, 0, 0, 32'h0,         32'h33333333, V,     1, 0, 0, 0, 32'h0);
      // reset while in WAIT, then a clean fetch
      add(1, V,  0, 0, 0, 0, 32'h0,         32'h33333333, V,     1, 0, 0, 0, 32'h0);
      add(0, A,  0, 0, 0, 1, 32'h55555555,  32'h0,        32'h0, 1, 0, 0, 0, 32'h0);
      add(0, A,  0, 0, 1, 0, 32'h0,         32'h0,        32'h0, 1, 0, 0, 1, A);
      add(0, A,  0, 0, 0, 1, 32'h3c080001,  32'h0,        32'h0, 1, 0, 0, 0, 32'h0);
      add(0, A,  0, 0, 0, 0, 32'h0,         32'h3c080001, A,     0, 0, 1, 0, 32'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].pc, vecs[i].stall, vecs[i].flush,
               vecs[i].aok, vecs[i].dok, vecs[i].rdata);
         check($sformatf("vec%0d", i), vecs[i].eInstr, vecs[i].ePc, vecs[i].eStallreq,
               vecs[i].eClear, vecs[i].eDok, vecs[i].eReq, vecs[i].eAddr);
      end

      // Back-to-back zero-wait fetches: one instruction every three cycles
      for (int k = 0; k < 3; k++) begin
         logic [31:0] pc;
         logic [31:0] rd;
         logic [31:0] prevI;
         logic [31:0] prevP;
         pc    = 32'h80000000 + 32'(4 * k);
         rd    = 32'h01010101 * 32'(k + 1);
         prevI = (k == 0) ? 32'h3c080001 : 32'h01010101 * 32'(k);
         prevP = (k == 0) ? A : 32'h80000000 + 32'(4 * (k - 1));
         drive(0, pc, 0, 0, 1, 0, 32'h0);
         check($sformatf("tput%0d_req", k), prevI, prevP, 1, 0, 0, 1, pc);
         drive(0, pc, 0, 0, 0, 1, rd);
         check($sformatf("tput%0d_wait", k), prevI, prevP, 1, 0, 0, 0, 32'h0);
         drive(0, pc, 0, 0, 0, 0, 32'h0);
         check($sformatf("tput%0d_done", k), rd, pc, 0, 0, 1, 0, 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
`default_nettype wire
